alu_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared RV32I ALU. Two requesters, for example the execute stage and a branch/address helper, issue operand/opcode transactions over valid/ready handshakes. The arbiter grants one requester at a time in round-robin order, registers the operands, drives a single internal `alu` instance, and returns the registered result on a shared response channel tagged with the requester ID. One transaction is in flight at a time.

---
 rtl/alu_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end for a shared RV32I ALU: two valid/ready requesters,
// one transaction in flight, and a registered response tagged with the winner's ID.

module alu #(
  parameter int W = 32
) (
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic [3:0]   alu_op,
  output logic [W-1:0] result,
  output logic         err
);
  localparam int SW = $clog2(W);

  logic [SW-1:0] shamt;
  assign shamt = op2[SW-1:0];

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (alu_op)
      4'd0:    result = op1 + op2;
      4'd1:    result = op1 - op2;
      4'd2:    result = op1 & op2;
      4'd3:    result = op1 | op2;
      4'd4:    result = op1 ^ op2;
      4'd5:    result = op1 << shamt;
      4'd6:    result = op1 >> shamt;
      4'd7:    result = $unsigned($signed(op1) >>> shamt);
      4'd8:    result = {{(W-1){1'b0}}, ($signed(op1) < $signed(op2))};
      4'd9:    result = {{(W-1){1'b0}}, (op1 < op2)};
      default: err = 1'b1;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int ALU_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ALU_WIDTH-1:0] req0_op1,
  input  logic [ALU_WIDTH-1:0] req0_op2,
  input  logic [3:0]           req0_alu_op,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ALU_WIDTH-1:0] req1_op1,
  input  logic [ALU_WIDTH-1:0] req1_op2,
  input  logic [3:0]           req1_alu_op,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [ALU_WIDTH-1:0] resp_data,
  output logic                 resp_zero,
  output logic                 resp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [ALU_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [3:0]           op_q, op_d;
  logic                 id_q, id_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_id_q, resp_id_d;
  logic [ALU_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                 resp_zero_q, resp_zero_d;
  logic                 resp_err_q, resp_err_d;

  logic [ALU_WIDTH-1:0] alu_result;
  logic                 alu_err;
  logic                 gnt0, gnt1;

  alu #(.W(ALU_WIDTH)) u_alu (
    .op1(op1_q), .op2(op2_q), .alu_op(op_q), .result(alu_result), .err(alu_err)
  );

  // On a tie the requester that did not win last time goes first.
  assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);
  assign req0_ready = (state_q == IDLE) & ~rst & gnt0;
  assign req1_ready = (state_q == IDLE) & ~rst & gnt1;

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_zero  = resp_zero_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    op_d         = op_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_zero_d  = resp_zero_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: if (req0_ready | req1_ready) begin
        op1_d        = req1_ready ? req1_op1    : req0_op1;
        op2_d        = req1_ready ? req1_op2    : req0_op2;
        op_d         = req1_ready ? req1_alu_op : req0_alu_op;
        id_d         = req1_ready;
        last_grant_d = req1_ready;
        state_d      = EXEC;
      end
      EXEC: begin
        resp_data_d  = alu_result;
        resp_zero_d  = (alu_result == '0);
        resp_err_d   = alu_err;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op1_q        <= '0;
      op2_q        <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      op_q         <= op_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_zero_q  <= resp_zero_d;
      resp_err_q   <= resp_err_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level reference of the arbiter and ALU.

module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [3:0]  req0_alu_op = '0, req1_alu_op = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_id, resp_zero, resp_err;
  logic [31:0] resp_data;

  alu_arbiter #(.ALU_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_alu_op(req0_alu_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_alu_op(req1_alu_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic id; logic err; logic [31:0] data;} exp_t;

  int   n_checks = 0, n_err = 0, cyc = 0;
  bit   m_busy = 1'b0, m_last = 1'b1;
  int   m_acc = 0;
  exp_t m_exp;
  bit   acc0, acc1;
  logic last_rdy0, last_rdy1;
  logic [31:0] rlog_data[$];
  logic        rlog_id[$], rlog_zero[$], rlog_err[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  sh;
    logic [31:0] d;
    logic        e;
    sh = b[4:0];
    d  = '0;
    e  = 1'b0;
    case (op)
      4'd0: d = a + b;
      4'd1: d = a - b;
      4'd2: d = a & b;
      4'd3: d = a | b;
      4'd4: d = a ^ b;
      4'd5: d = a << sh;
      4'd6: d = a >> sh;
      4'd7: begin d = a >> sh; if (a[31]) d = d | ~(32'hFFFF_FFFF >> sh); end
      4'd8: d = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd9: d = (a < b) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
    return {e, d};
  endfunction

  // One cycle: sample and check at the falling edge, then advance past the rising edge.
  task automatic tick();
    logic        e0, e1, erv;
    logic [32:0] r;
    @(negedge clk);
    cyc++;
    acc0 = 1'b0;
    acc1 = 1'b0;
    last_rdy0 = req0_ready;
    last_rdy1 = req1_ready;
    if (rst) begin
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      m_busy = 1'b0;
      m_last = 1'b1;
    end else begin
      e0  = !m_busy && req0_valid && (!req1_valid || m_last);
      e1  = !m_busy && req1_valid && (!req0_valid || !m_last);
      erv = m_busy && (cyc - m_acc >= 2);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("resp_valid", resp_valid, erv);
      if (erv) begin
        chk("resp_id", resp_id, m_exp.id);
        chk("resp_data", resp_data, m_exp.data);
        chk("resp_zero", resp_zero, (m_exp.data == 0));
        chk("resp_err", resp_err, m_exp.err);
        if (resp_ready) begin
          rlog_data.push_back(resp_data);
          rlog_id.push_back(resp_id);
          rlog_zero.push_back(resp_zero);
          rlog_err.push_back(resp_err);
          m_busy = 1'b0;
        end
      end else if (e0 || e1) begin
        r = e1 ? ref_alu(req1_alu_op, req1_op1, req1_op2) : ref_alu(req0_alu_op, req0_op1, req0_op2);
        m_exp.id   = e1;
        m_exp.err  = r[32];
        m_exp.data = r[31:0];
        m_busy = 1'b1;
        m_acc  = cyc;
        m_last = e1;
        acc0 = e0;
        acc1 = e1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin req1_valid = 1'b1; req1_alu_op = op; req1_op1 = a; req1_op2 = b; end
    else    begin req0_valid = 1'b1; req0_alu_op = op; req0_op1 = a; req0_op2 = b; end
  endtask

  task automatic wait_acc(input bit id);
    int g;
    g = 0;
    acc0 = 1'b0;
    acc1 = 1'b0;
    while (!(id ? acc1 : acc0) && g < 20) begin tick(); g++; end
    chk("accept_wait", (g < 20) ? 1 : 0, 1);
  endtask

  task automatic wait_resps(input int n);
    int g;
    g = 0;
    while (rlog_data.size() < n && g < 60) begin tick(); g++; end
    chk("resp_wait", (g < 60) ? 1 : 0, 1);
  endtask

  task automatic send(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n0;
    n0 = rlog_data.size();
    resp_ready = 1'b1;
    set_req(id, op, a, b);
    wait_acc(id);
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    wait_resps(n0 + 1);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [3:0]  f_op[5];
  logic [31:0] f_a[5], f_b[5], f_d[5];
  logic        f_z[5], f_e[5];

  initial begin
    int n0;
    f_op = '{4'd0, 4'd9, 4'd8, 4'd5, 4'd12};
    f_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd5};
    f_b  = '{32'd1, 32'd1, 32'd1, 32'h24, 32'd7};
    f_d  = '{32'd0, 32'd0, 32'd1, 32'h10, 32'd0};
    f_z  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    f_e  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset asserted between edges: outputs clear at once.
    #2 rst = 1'b1;
    #1;
    chk("por_resp_valid", resp_valid, 0);
    chk("por_resp_data", resp_data, 0);
    chk("por_resp_id", resp_id, 0);
    chk("por_resp_zero", resp_zero, 0);
    chk("por_resp_err", resp_err, 0);
    chk("por_rdy0", req0_ready, 0);
    chk("por_rdy1", req1_ready, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single request.
    send(0, 4'd0, 32'h10, 32'h20);
    chk("single_data", rlog_data[$], 32'h30);
    chk("single_id", rlog_id[$], 0);
    chk("single_zero", rlog_zero[$], 0);
    chk("single_err", rlog_err[$], 0);

    // Async reset while a response is pending.
    resp_ready = 1'b0;
    set_req(0, 4'd0, 32'd1, 32'd1);
    wait_acc(0);
    req0_valid = 1'b0;
    tick();
    chk("pend_resp_valid", resp_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_resp_valid", resp_valid, 0);
    chk("mid_resp_data", resp_data, 0);
    chk("mid_resp_zero", resp_zero, 0);
    tick();
    rst = 1'b0;

    // Round robin with both requesters held valid.
    do_reset();
    resp_ready = 1'b1;
    set_req(0, 4'd1, 32'h30, 32'h20);
    set_req(1, 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    n0 = rlog_data.size();
    wait_resps(n0 + 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rr_id", rlog_id[n0 + i], i % 2);
      chk("rr_data", rlog_data[n0 + i], (i % 2) ? 32'hFF00_FF00 : 32'h10);
    end

    // Backpressure: req1 response held while req0 waits.
    set_req(1, 4'd7, 32'h8000_0000, 32'd2);
    wait_acc(1);
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    set_req(0, 4'd0, 32'd5, 32'd6);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", resp_valid, 1);
      chk("bp_data", resp_data, 32'hE000_0000);
      chk("bp_id", resp_id, 1);
      chk("bp_rdy0", req0_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_next_rdy0", req0_ready, 1);
    tick();
    chk("bp_next_acc0", acc0, 1);
    req0_valid = 1'b0;
    n0 = rlog_data.size();
    wait_resps(n0 + 1);
    chk("bp_next_data", rlog_data[$], 32'd11);

    // Flag and edge cases.
    for (int i = 0; i < 5; i++) begin
      send(i[0], f_op[i], f_a[i], f_b[i]);
      chk("edge_data", rlog_data[$], f_d[i]);
      chk("edge_zero", rlog_zero[$], f_z[i]);
      chk("edge_err", rlog_err[$], f_e[i]);
      chk("edge_id", rlog_id[$], i % 2);
    end

    // Make req1 the last winner, then reset mid-EXEC of a req0 transaction.
    send(1, 4'd2, 32'hFF, 32'h0F);
    set_req(0, 4'd0, 32'd3, 32'd4);
    wait_acc(0);
    #2 rst = 1'b1;
    #1;
    chk("exec_rst_valid", resp_valid, 0);
    req0_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("exec_rst_no_resp", resp_valid, 0);
    end
    set_req(0, 4'd0, 32'd3, 32'd4);
    set_req(1, 4'd0, 32'd7, 32'd8);
    tick();
    chk("rst_tie_rdy0", last_rdy0, 1);
    chk("rst_tie_rdy1", last_rdy1, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      tick();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(0, 2) == 0)
        set_req(0, 4'($urandom_range(0, 15)), rnd_val(), rnd_val());
      if (!req1_valid && $urandom_range(0, 2) == 0)
        set_req(1, 4'($urandom_range(0, 15)), rnd_val(), rnd_val());
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
